// File: rtl/uart_tx_gen.sv
// uart_tx_gen
//   Parametrised UART transmitter with an input FIFO and internal baud divider.
//   Words are accepted over a valid/ready handshake, queued, then serialised
//   LSB-first as start, DATA_BITS data, optional parity, STOP_BITS stop bits.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   in_data     word to transmit (DATA_BITS wide)
//   in_valid    in_data valid
//   in_ready    FIFO can accept a word (not full)
//   tx          serial line, idle high, registered
//   busy        frame in progress or FIFO non-empty
//   fifo_count  words held in the FIFO (the word in the shifter is not counted)
module uart_tx_gen #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned BAUD_W    = $clog2(STOP_CLKS);
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];
    assign head_par = (PARITY == 2) ? (^head) : ~(^head);

    // Storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state, state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 bit_end;
    logic                 stop_end;
    logic                 bit_last;

    assign bit_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign stop_end = (baud_cnt == BAUD_W'(STOP_CLKS - 1));
    assign bit_last = (bit_cnt == BIT_W'(DATA_BITS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            par_bit  <= par_next;
            tx       <= tx_next;
        end
    end

    // Next-state logic; a pop loads the shifter and computes parity at once.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BAUD_W'(1);
        bit_next   = bit_cnt;
        shift_next = shift;
        par_next   = par_bit;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shift_next = head;
                    par_next   = head_par;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_last) begin
                        state_next = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        shift_next = shift >> 1;
                        bit_next   = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (stop_end) begin
                    baud_next = '0;
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        shift_next = head;
                        par_next   = head_par;
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: tx is registered, so its next value is decoded from the
    // next state and next shifter contents rather than the current ones.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PAR:     tx_next = par_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    assign busy = (state != IDLE) | (fifo_count != '0);

endmodule
